// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse front-end: FSM states, symbol layout
// and element limits used by the framer and its symbol FIFO.
package morse_pkg;

    localparam int ELEM_MAX   = 6;
    localparam int SYM_LEN_W  = 3;
    localparam int SYM_BITS_W = 6;
    localparam int SYM_W      = 1 + SYM_LEN_W + SYM_BITS_W;

    localparam logic [7:0] ASCII_SPACE = 8'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  space;
        logic [SYM_LEN_W-1:0]  len;
        logic [SYM_BITS_W-1:0] bits;
    } sym_t;

    function automatic sym_t make_char(input logic [SYM_LEN_W-1:0] len,
                                       input logic [SYM_BITS_W-1:0] bits);
        sym_t s;
        s.space = 1'b0;
        s.len   = len;
        s.bits  = bits;
        return s;
    endfunction

    function automatic sym_t make_space();
        sym_t s;
        s = '0;
        s.space = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/morse_sym_fifo.sv
// Small synchronous FIFO for completed symbols; the head is presented directly
// from storage and reads as zero whenever the FIFO is empty.
module morse_sym_fifo
    import morse_pkg::*;
#(
    parameter int WIDTH = SYM_W,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // The extra pointer bit separates a full FIFO from an empty one.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/morse_frame_ctrl.sv
// Morse key front-end: synchronises the key line, times marks and gaps, frames
// dot/dash elements into characters and word spaces, and queues the symbols.
module morse_frame_ctrl
    import morse_pkg::*;
#(
    parameter int CLKS_PER_UNIT = 1000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       signal_in,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       sym_space,
    output logic [2:0] sym_len,
    output logic [5:0] sym_bits,
    output logic       busy,
    output logic       overflow,
    output logic       len_error
);

    localparam int RUN_MAX = 8 * CLKS_PER_UNIT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] HALF_U  = RUN_W'(CLKS_PER_UNIT / 2);
    localparam logic [RUN_W-1:0] TWO_U   = RUN_W'(2 * CLKS_PER_UNIT);
    localparam logic [RUN_W-1:0] FIVE_U  = RUN_W'(5 * CLKS_PER_UNIT);

    logic                  sync1_q, sync2_q, sync3_q;
    logic [RUN_W-1:0]      run_q;
    state_t                state_q;
    logic [SYM_LEN_W-1:0]  count_q;
    logic [SYM_BITS_W-1:0] bits_q;
    logic                  err_q;
    logic                  word_armed_q;
    logic                  push_q;
    sym_t                  push_data_q;
    logic                  len_error_q;
    logic                  overflow_q;

    logic                  rise, fall;
    logic                  sym_pop;
    logic                  fifo_full, fifo_empty;
    logic [SYM_W-1:0]      head_raw;
    sym_t                  head;

    assign rise = sync2_q && !sync3_q;
    assign fall = !sync2_q && sync3_q;

    // Timing and framing FSM; an edge on s always wins over a threshold match.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            run_q        <= '0;
            state_q      <= ST_IDLE;
            count_q      <= '0;
            bits_q       <= '0;
            err_q        <= 1'b0;
            word_armed_q <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            len_error_q  <= 1'b0;
        end else begin
            sync1_q     <= signal_in;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            push_q      <= 1'b0;
            len_error_q <= 1'b0;

            if (rise || fall)
                run_q <= RUN_W'(1);
            else if (run_q != RUN_SAT)
                run_q <= run_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (rise) state_q <= ST_MARK;
                end

                ST_MARK: begin
                    if (fall) begin
                        if (run_q < HALF_U) begin
                            state_q <= (count_q != '0) ? ST_GAP : ST_IDLE;
                        end else begin
                            if (count_q == SYM_LEN_W'(ELEM_MAX)) begin
                                err_q <= 1'b1;
                            end else begin
                                bits_q  <= {bits_q[SYM_BITS_W-2:0], (run_q >= TWO_U)};
                                count_q <= count_q + 1'b1;
                            end
                            state_q <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (rise) begin
                        state_q <= ST_MARK;
                    end else if (run_q == TWO_U && count_q != '0) begin
                        if (err_q) begin
                            len_error_q <= 1'b1;
                            err_q       <= 1'b0;
                        end else begin
                            push_q       <= 1'b1;
                            push_data_q  <= make_char(count_q, bits_q);
                            word_armed_q <= 1'b1;
                        end
                        count_q <= '0;
                        bits_q  <= '0;
                    end else if (run_q == FIVE_U) begin
                        if (word_armed_q) begin
                            push_q      <= 1'b1;
                            push_data_q <= make_space();
                        end
                        word_armed_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sym_pop = sym_valid && sym_ready;

    // A push that finds the FIFO full is only lost if no pop frees a slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            overflow_q <= 1'b0;
        else if (push_q && fifo_full && !sym_pop)
            overflow_q <= 1'b1;
    end

    morse_sym_fifo #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (sym_pop),
        .head_o      (head_raw),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head      = sym_t'(head_raw);
    assign sym_valid = !fifo_empty;
    assign sym_space = head.space;
    assign sym_len   = head.len;
    assign sym_bits  = head.bits;
    assign busy      = (state_q != ST_IDLE);
    assign overflow  = overflow_q;
    assign len_error = len_error_q;

endmodule

// File: tb/tb_morse_frame_ctrl.sv
// Directed bench for morse_frame_ctrl with a 10-cycle Morse unit; popped
// symbols and len_error pulses are collected by a negedge monitor.
module tb_morse_frame_ctrl;

    logic       clock;
    logic       reset_n;
    logic       signal_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       sym_space;
    logic [2:0] sym_len;
    logic [5:0] sym_bits;
    logic       busy;
    logic       overflow;
    logic       len_error;

    int total = 0;
    int bad   = 0;
    int errPulses = 0;
    logic [9:0] cap[$];

    morse_frame_ctrl #(
        .CLKS_PER_UNIT (10),
        .FIFO_DEPTH    (4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .signal_in (signal_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_space (sym_space),
        .sym_len   (sym_len),
        .sym_bits  (sym_bits),
        .busy      (busy),
        .overflow  (overflow),
        .len_error (len_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every handshake and every len_error pulse, away from the edge.
    always @(negedge clock) begin
        if (sym_valid && sym_ready) cap.push_back({sym_space, sym_len, sym_bits});
        if (len_error) errPulses++;
    end

    task automatic applyStimulus(input logic lvl, input int n);
        signal_in = lvl;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic keyDot(input int gap);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, gap);
    endtask

    task automatic keyDash(input int gap);
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, gap);
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        signal_in = 1'b0;
        sym_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++; if (sym_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", sym_valid); end
        total++; if ({sym_space, sym_len, sym_bits} !== 10'd0) begin bad++; $display("[TB] FAIL reset_head got=%h want=000", {sym_space, sym_len, sym_bits}); end
        total++; if ({busy, overflow, len_error} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", {busy, overflow, len_error}); end
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic test_char_a;
        sym_ready = 1'b1;
        cap.delete();
        errPulses = 0;
        keyDot(10);
        keyDash(30);
        applyStimulus(1'b0, 5);
        total++; if (cap.size() !== 1) begin bad++; $display("[TB] FAIL a_count got=%0d want=1", cap.size()); end
        else begin
            total++; if (cap[0] !== {1'b0, 3'd2, 6'b000001}) begin bad++; $display("[TB] FAIL a_symbol got=%h want=%h", cap[0], {1'b0, 3'd2, 6'b000001}); end
        end
        total++; if (errPulses !== 0) begin bad++; $display("[TB] FAIL a_len_error got=%0d want=0", errPulses); end
    endtask

    task automatic test_word_space;
        applyStimulus(1'b0, 50);
        total++; if (cap.size() !== 2) begin bad++; $display("[TB] FAIL space_count got=%0d want=2", cap.size()); end
        else begin
            total++; if (cap[1] !== {1'b1, 3'd0, 6'd0}) begin bad++; $display("[TB] FAIL space_symbol got=%h want=200", cap[1]); end
        end
        applyStimulus(1'b0, 200);
        total++; if (cap.size() !== 2) begin bad++; $display("[TB] FAIL space_single got=%0d want=2", cap.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL space_busy got=%b want=0", busy); end
    endtask

    task automatic test_glitch;
        cap.delete();
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 100);
        total++; if (cap.size() !== 0) begin bad++; $display("[TB] FAIL glitch_none got=%0d want=0", cap.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy got=%b want=0", busy); end
        keyDash(10);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 10);
        keyDot(30);
        total++; if (cap.size() !== 1) begin bad++; $display("[TB] FAIL n_count got=%0d want=1", cap.size()); end
        else begin
            total++; if (cap[0] !== {1'b0, 3'd2, 6'b000010}) begin bad++; $display("[TB] FAIL n_symbol got=%h want=%h", cap[0], {1'b0, 3'd2, 6'b000010}); end
        end
        applyStimulus(1'b0, 60);
        total++; if (cap.size() !== 2) begin bad++; $display("[TB] FAIL n_space got=%0d want=2", cap.size()); end
    endtask

    task automatic test_overflow;
        logic [9:0] held;
        cap.delete();
        sym_ready = 1'b0;
        for (int i = 0; i < 5; i++) keyDot(30);
        applyStimulus(1'b0, 5);
        total++; if (sym_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovf_valid got=%b want=1", sym_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", overflow); end
        held = {sym_space, sym_len, sym_bits};
        total++; if (held !== {1'b0, 3'd1, 6'd0}) begin bad++; $display("[TB] FAIL ovf_head got=%h want=%h", held, {1'b0, 3'd1, 6'd0}); end
        applyStimulus(1'b0, 70);
        total++; if ({sym_space, sym_len, sym_bits} !== held) begin bad++; $display("[TB] FAIL ovf_stable got=%h want=%h", {sym_space, sym_len, sym_bits}, held); end
        sym_ready = 1'b1;
        applyStimulus(1'b0, 10);
        sym_ready = 1'b0;
        total++; if (cap.size() !== 4) begin bad++; $display("[TB] FAIL drain_count got=%0d want=4", cap.size()); end
        for (int i = 0; i < cap.size(); i++) begin
            total++; if (cap[i] !== {1'b0, 3'd1, 6'd0}) begin bad++; $display("[TB] FAIL drain_symbol%0d got=%h want=%h", i, cap[i], {1'b0, 3'd1, 6'd0}); end
        end
        total++; if (sym_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_empty got=%b want=0", sym_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_len_error;
        cap.delete();
        errPulses = 0;
        sym_ready = 1'b1;
        for (int i = 0; i < 7; i++) keyDot((i == 6) ? 30 : 10);
        total++; if (errPulses !== 1) begin bad++; $display("[TB] FAIL lenerr_pulses got=%0d want=1", errPulses); end
        total++; if (cap.size() !== 0) begin bad++; $display("[TB] FAIL lenerr_nosym got=%0d want=0", cap.size()); end
        keyDash(30);
        total++; if (cap.size() !== 1) begin bad++; $display("[TB] FAIL t_count got=%0d want=1", cap.size()); end
        else begin
            total++; if (cap[0] !== {1'b0, 3'd1, 6'b000001}) begin bad++; $display("[TB] FAIL t_symbol got=%h want=%h", cap[0], {1'b0, 3'd1, 6'b000001}); end
        end
        applyStimulus(1'b0, 60);
    endtask

    task automatic test_reset_midchar;
        sym_ready = 1'b0;
        keyDot(30);
        keyDot(30);
        applyStimulus(1'b1, 15);
        total++; if (sym_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL midreset_pre got=%b%b want=11", sym_valid, busy); end
        reset_n = 1'b0;
        #1;
        total++; if ({sym_valid, sym_space, sym_len, sym_bits} !== 11'd0) begin bad++; $display("[TB] FAIL midreset_head got=%h want=000", {sym_valid, sym_space, sym_len, sym_bits}); end
        total++; if ({busy, overflow, len_error} !== 3'b000) begin bad++; $display("[TB] FAIL midreset_flags got=%b want=000", {busy, overflow, len_error}); end
        signal_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b0, 20);
        cap.delete();
        sym_ready = 1'b1;
        keyDot(10);
        keyDot(10);
        keyDot(30);
        total++; if (cap.size() !== 1) begin bad++; $display("[TB] FAIL s_count got=%0d want=1", cap.size()); end
        else begin
            total++; if (cap[0] !== {1'b0, 3'd3, 6'd0}) begin bad++; $display("[TB] FAIL s_symbol got=%h want=%h", cap[0], {1'b0, 3'd3, 6'd0}); end
        end
        applyStimulus(1'b0, 60);
    endtask

    initial begin
        $display("[TB] start");
        test_reset;
        test_char_a;
        test_word_space;
        test_glitch;
        test_overflow;
        test_len_error;
        test_reset_midchar;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_frame_ctrl.md
Name: morse_frame_ctrl

Overview:
Front-end controller that sits between the raw Morse key line and the character lookup stage. It synchronises and times the keyed signal, classifies each mark as a dot or a dash, and frames the elements into characters and word spaces. Completed symbols are buffered in a small FIFO and handed to the lookup stage over a valid/ready handshake, so that stage runs once per character rather than once per clock.

Parameters:
CLKS_PER_UNIT, 1000, clock cycles in one Morse time unit (≥8)
FIFO_DEPTH, 4, symbol FIFO entries (power of 2, ≥2)

Ports:
clock       in   1  system clock, rising edge
reset_n     in   1  asynchronous, active-low reset
signal_in   in   1  raw key line, 1 = mark, asynchronous to clock
sym_valid   out  1  FIFO head holds a symbol
sym_ready   in   1  consumer accepts head this cycle
sym_space   out  1  head is a word-space token (sym_len = 0, sym_bits = 0)
sym_len     out  3  element count 1..6
sym_bits    out  6  elements, 1 = dash; first element at bit sym_len-1, unused upper bits 0
busy        out  1  state != IDLE
overflow    out  1  sticky: a symbol was dropped because the FIFO was full
len_error   out  1  one-cycle pulse: character exceeded 6 elements and was discarded

Behaviour:
- Reset (async, reset_n = 0): all outputs 0; synchroniser, counters, element register and FIFO pointers cleared; state IDLE. Reset mid-character discards the partial character and any buffered symbols.
- Synchroniser: 2-flop on signal_in, reset to 0. The synchronised level is "s". All timing below is measured on s, so there is 2 cycles of latency from the pin.
- Run counter: counts cycles since the last edge of s; cleared to 1 on each edge; saturates at 8*CLKS_PER_UNIT.
- U denotes CLKS_PER_UNIT.
- States:
  - IDLE: no pending elements, s = 0. Rising edge -> MARK.
  - MARK: on falling edge, classify by run length r:
    - r < U/2: glitch, ignored. Go to GAP if elements are pending, else IDLE.
    - U/2 ≤ r < 2U: dot.
    - r ≥ 2U: dash.
    - A dot or dash is shifted into the element register and the count is incremented, then -> GAP.
    - If the count is already 6: set the error flag, stay in framing, and discard the element.
  - GAP: rising edge -> MARK (intra-character gap).
    - When the run reaches exactly 2U with elements pending: push {space=0, len, bits}, clear the element register, set word_armed, and stay in GAP.
    - If the error flag is set at that point: push nothing, pulse len_error for 1 cycle, and clear the flag.
    - When the run reaches exactly 5U with word_armed = 1: push the space token, clear word_armed, -> IDLE.
    - When the run reaches 5U with word_armed = 0: -> IDLE.
- Only one word-space token is emitted per silence; no token is emitted before the first character.
- FIFO:
  - sym_valid = not empty. Head fields are registered and held stable while sym_valid && !sym_ready.
  - A pop occurs on sym_valid && sym_ready.
  - A pushed symbol appears at the head 1 cycle after push when the FIFO was empty.
  - Push while full with no pop in that cycle: symbol dropped, overflow set (sticky until reset).
  - Push and pop in the same cycle while full: both succeed and overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.
- Simultaneous events: an edge of s in the same cycle as a threshold match takes priority; the threshold action is not taken.

Decomposition:
- Shared package morse_pkg:
  - ELEM_MAX = 6
  - symbol struct/field widths (space 1, len 3, bits 6; 10-bit entry)
  - state encoding IDLE/MARK/GAP
  - ASCII constants for SPACE (32)
- One natural sub-module: morse_sym_fifo, a parameterised synchronous FIFO with valid/ready pop, a push input, and full/empty outputs.
- Timing, classification and framing stay in the top module.

Test Plan:
(All scenarios use CLKS_PER_UNIT = 10.)
1. 'A': high 10, low 10, high 30, low 30 -> one symbol sym_space=0, sym_len=2, sym_bits=6'b000001; len_error=0.
2. 'A' followed by low ≥70 -> second symbol sym_space=1, sym_len=0. Holding low for a further 200 cycles yields no further symbols; busy=0.
3. Glitch: high 4, low 100 -> no symbol, busy returns to 0. High 4 inside 'N' (dash, gap 10, glitch 4, gap 10, dot) -> sym_len=2, bits=2'b10.
4. sym_ready=0, key five 'E' (high 10, low 30 each) -> 4 entries buffered, overflow=1. Draining then yields four symbols len=1 bits=0, with head data stable while stalled.
5. Seven dots separated by 10-cycle gaps, then low 30 -> len_error pulses once, no symbol. A following 'T' (high 30, low 30) decodes as len=1 bits=1.
6. reset_n low for 3 cycles in the middle of a dash with 2 symbols buffered -> all outputs 0 immediately. After release, 'S' (three dots) yields exactly one symbol len=3 bits=0.
